// File: rtl/axis_tb_pkg.sv
// axis_tb_pkg: shared definitions for the AXI4-Stream capture slave.
//   state_e          - throttling FSM states (ACCEPT / STALL)
//   AXIS_DATA_W      - default stream data width
//   AXIS_FULL_STRB   - all-ones byte strobe for the default width
//   PKT_COUNT_W      - width of the wrapping packet counter
//   stall_cnt_width  - width needed to hold a stall-cycle count
//   fifo_count_width - width needed to hold an occupancy of 0..depth
package axis_tb_pkg;

  typedef enum logic [0:0] {
    ACCEPT = 1'b0,
    STALL  = 1'b1
  } state_e;

  localparam int AXIS_DATA_W = 32;
  localparam int AXIS_STRB_W = AXIS_DATA_W / 8;
  localparam logic [AXIS_STRB_W-1:0] AXIS_FULL_STRB = {AXIS_STRB_W{1'b1}};
  localparam int PKT_COUNT_W = 16;

  // A zero or one cycle stall still needs a one-bit counter so the port exists.
  function automatic int stall_cnt_width(input int stall_cycles);
    return (stall_cycles < 2) ? 1 : $clog2(stall_cycles + 1);
  endfunction

  // Occupancy must represent the full value, hence one bit above the pointer.
  function automatic int fifo_count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_capture_fifo.sv
// axis_capture_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst_n      - clock and asynchronous active-low reset
//   wr_en, wr_data  - push a word (ignored while full)
//   rd_en           - pop the head word (ignored while empty)
//   rd_data         - head word, valid whenever empty is low
//   full, empty     - occupancy flags derived from the registered count
//   count           - number of words held
module axis_capture_fifo
  import axis_tb_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = fifo_count_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_fire_s, rd_fire_s;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == CW'(0));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Next pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    wr_fire_s = wr_en && !full;
    rd_fire_s = rd_en && !empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (wr_fire_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_fire_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_fire_s, rd_fire_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards any buffered words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/axi_stream_slave_tb.sv
// axi_stream_slave_tb: AXI4-Stream receiver model that captures a DUT's output
// stream into a FWFT FIFO for later checking, with optional tready throttling.
//   s00_axis_*   - AXI4-Stream slave interface (tready is register-driven)
//   rd_en        - pop the head word
//   rd_data/last - head word and its stored tlast flag
//   rd_empty, fifo_full, fifo_count - buffer status
//   pkt_avail    - at least one complete packet is buffered
//   pkt_count    - wrapping count of accepted tlast words
//   strb_err     - sticky flag: a word arrived with a partial strobe
module axi_stream_slave_tb
  import axis_tb_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = AXIS_DATA_W,
  parameter int FIFO_DEPTH           = 64,
  parameter int READY_STALL_CYCLES   = 0
) (
  input  logic                              s00_axis_aclk,
  input  logic                              s00_axis_aresetn,
  input  logic                              s00_axis_tvalid,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                              s00_axis_tlast,
  output logic                              s00_axis_tready,
  input  logic                              rd_en,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   rd_data,
  output logic                              rd_last,
  output logic                              rd_empty,
  output logic                              fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
  output logic                              pkt_avail,
  output logic [15:0]                       pkt_count,
  output logic                              strb_err
);

  localparam int DW     = C_S_AXIS_TDATA_WIDTH;
  localparam int STRB_W = DW / 8;
  localparam int CW     = fifo_count_width(FIFO_DEPTH);
  localparam int SCW    = stall_cnt_width(READY_STALL_CYCLES);
  localparam bit STALL_EN = (READY_STALL_CYCLES > 0);
  localparam logic [SCW-1:0] STALL_LOAD = SCW'(READY_STALL_CYCLES);

  state_e                 state_q, state_d;
  logic [SCW-1:0]         stall_cnt_q, stall_cnt_d;
  logic                   ready_en_q, ready_en_d;
  logic [PKT_COUNT_W-1:0] pkt_count_q, pkt_count_d;
  logic [CW-1:0]          pend_pkts_q, pend_pkts_d;
  logic                   strb_err_q, strb_err_d;

  logic                   accept_s, pop_s;
  logic                   fifo_empty_s, fifo_full_s;
  logic [DW:0]            head_word_s;
  logic [CW-1:0]          fifo_count_s;

  // tready depends only on registers, never on tvalid.
  assign s00_axis_tready = ready_en_q && (state_q == ACCEPT) && !fifo_full_s;
  assign accept_s        = s00_axis_tvalid && s00_axis_tready;
  assign pop_s           = rd_en && !fifo_empty_s;

  axis_capture_fifo #(
    .WIDTH (DW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (s00_axis_aclk),
    .rst_n   (s00_axis_aresetn),
    .wr_en   (accept_s),
    .wr_data ({s00_axis_tlast, s00_axis_tdata}),
    .rd_en   (rd_en),
    .rd_data (head_word_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  assign rd_data    = head_word_s[DW-1:0];
  assign rd_last    = head_word_s[DW];
  assign rd_empty   = fifo_empty_s;
  assign fifo_full  = fifo_full_s;
  assign fifo_count = fifo_count_s;
  assign pkt_avail  = (pend_pkts_q != CW'(0));
  assign pkt_count  = pkt_count_q;
  assign strb_err   = strb_err_q;

  // Throttle FSM: after each accept tready drops for exactly STALL_LOAD cycles.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      ACCEPT: begin
        if (accept_s && STALL_EN) begin
          state_d     = STALL;
          stall_cnt_d = STALL_LOAD;
        end else begin
          state_d     = ACCEPT;
          stall_cnt_d = stall_cnt_q;
        end
      end
      STALL: begin
        // Leaving on a count of one makes the low period equal to the load value.
        if (stall_cnt_q <= SCW'(1)) begin
          state_d     = ACCEPT;
          stall_cnt_d = SCW'(0);
        end else begin
          state_d     = STALL;
          stall_cnt_d = stall_cnt_q - SCW'(1);
        end
      end
      default: begin
        state_d     = ACCEPT;
        stall_cnt_d = SCW'(0);
      end
    endcase
  end

  // Packet bookkeeping and the sticky strobe error.
  always_comb begin
    ready_en_d  = 1'b1;
    pkt_count_d = pkt_count_q;
    pend_pkts_d = pend_pkts_q;
    strb_err_d  = strb_err_q;
    if (accept_s && s00_axis_tlast) begin
      pkt_count_d = pkt_count_q + PKT_COUNT_W'(1);
    end else begin
      pkt_count_d = pkt_count_q;
    end
    case ({accept_s && s00_axis_tlast, pop_s && rd_last})
      2'b10:   pend_pkts_d = pend_pkts_q + CW'(1);
      2'b01:   pend_pkts_d = pend_pkts_q - CW'(1);
      default: pend_pkts_d = pend_pkts_q;
    endcase
    if (accept_s && (s00_axis_tstrb != {STRB_W{1'b1}})) begin
      strb_err_d = 1'b1;
    end else begin
      strb_err_d = strb_err_q;
    end
  end

  // State registers; ready_en holds tready low until the first edge after reset.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q     <= ACCEPT;
      stall_cnt_q <= SCW'(0);
      ready_en_q  <= 1'b0;
      pkt_count_q <= PKT_COUNT_W'(0);
      pend_pkts_q <= CW'(0);
      strb_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      ready_en_q  <= ready_en_d;
      pkt_count_q <= pkt_count_d;
      pend_pkts_q <= pend_pkts_d;
      strb_err_q  <= strb_err_d;
    end
  end

endmodule

// File: doc/axi_stream_slave_tb.md
Name: axi_stream_slave_tb

Overview:
- AXI4-Stream slave (receiver) bench model, the counterpart to the bench stream master that feeds the AES core.
- Accepts words from the DUT's master port and buffers each word, with its tlast flag, in an internal FIFO.
- Exposes a first-word-fall-through read port and packet counters so the checker can pop results and compare them against expected AES output.
- Programmable tready throttling exercises DUT backpressure handling.

Parameters:
- C_S_AXIS_TDATA_WIDTH, 32, slave-side data width in bits (multiple of 8).
- FIFO_DEPTH, 64, buffer depth in words; power of two, >=4.
- READY_STALL_CYCLES, 0, cycles tready is held low after each accepted word; 0 = no throttling.

Ports:
- s00_axis_aclk  in  1  single clock; all logic on its rising edge.
- s00_axis_aresetn  in  1  asynchronous, active-low reset.
- s00_axis_tvalid  in  1  master data valid.
- s00_axis_tdata  in  C_S_AXIS_TDATA_WIDTH  stream data.
- s00_axis_tstrb  in  C_S_AXIS_TDATA_WIDTH/8  byte strobes.
- s00_axis_tlast  in  1  last word of packet.
- s00_axis_tready  out  1  slave ready.
- rd_en  in  1  pop head word.
- rd_data  out  C_S_AXIS_TDATA_WIDTH  head word (FWFT).
- rd_last  out  1  tlast stored with head word.
- rd_empty  out  1  FIFO empty.
- fifo_full  out  1  FIFO full.
- fifo_count  out  clog2(FIFO_DEPTH)+1  words buffered.
- pkt_avail  out  1  at least one complete packet buffered.
- pkt_count  out  16  total tlast words accepted since reset; wraps at 2^16.
- strb_err  out  1  sticky: an accepted word had tstrb != all ones.

Behaviour:
- Reset (async assert, sync release): tready=0, fifo_count=0, rd_empty=1, fifo_full=0, pkt_avail=0, pkt_count=0, strb_err=0, FSM=ACCEPT, stall counter=0, ready_en flop=0.
  - ready_en sets on the first clock edge after release, so tready stays 0 through reset and that first cycle.
  - Reset mid-operation discards buffered data and the current stall.
- tready is driven only from registers: ready_en && (state==ACCEPT) && !fifo_full. It never depends on tvalid.
- Accept: tvalid && tready at the rising edge. Write {tlast, tdata} at the write pointer and advance it.
- FSM states:
  - ACCEPT: on accept with READY_STALL_CYCLES>0, go to STALL and load counter=READY_STALL_CYCLES.
  - STALL: decrement the counter each cycle; return to ACCEPT when it reaches 1. tready is low for exactly READY_STALL_CYCLES cycles.
  - With READY_STALL_CYCLES=0, the FSM stays in ACCEPT and back-to-back accepts are allowed (one word per cycle).
- Read port:
  - rd_data/rd_last reflect the head entry combinationally while !rd_empty.
  - rd_en && !rd_empty pops at the edge and advances the read pointer.
  - rd_en when empty is ignored; no underflow and no state change.
- Pointers: clog2(FIFO_DEPTH) bits, wrap naturally modulo depth. fifo_count tracks occupancy.
- Full handling: fifo_full = (fifo_count==FIFO_DEPTH), registered-derived. When full, tready is already low, so no overflow is possible.
- Simultaneous accept and pop: count unchanged, both pointers advance. This is legal when full? No: tready is 0 when full, so only the pop occurs; tready rises the next cycle.
- pkt_avail is backed by an internal complete-packet counter:
  - +1 on accepting a tlast word, -1 on popping a word with rd_last=1, unchanged if both occur.
  - pkt_avail = counter != 0.
- pkt_count increments on every accepted tlast word and wraps 0xFFFF->0.
- strb_err sets on any accept with tstrb != all ones and clears only on reset. The word is still stored.
- Latency: an accepted word is visible on rd_data and counted in fifo_count the cycle after the accept edge.

Decomposition:
- Shared package axis_tb_pkg:
  - state enum {ACCEPT, STALL}.
  - Default width constant AXIS_DATA_W=32.
  - Full-strobe helper constant.
  - Counter width localparams.
- Sub-module axis_capture_fifo: synchronous FWFT FIFO.
  - Stores {last, data} of width C_S_AXIS_TDATA_WIDTH+1, with wr_en/rd_en/full/empty/count.
  - Top level owns the FSM, tready, packet counters and strb_err.

Test Plan:
- Reset, then master sends 4 words 0x00000001..0x00000004 with tlast on the 4th, READY_STALL_CYCLES=0 -> tready low during reset plus 1 cycle, then high; 4 accepts in 4 consecutive cycles; fifo_count=4, pkt_avail=1, pkt_count=1; pops return 1..4 with rd_last=1 only on 4.
- READY_STALL_CYCLES=3, continuous tvalid, 3 words -> tready pattern 1,0,0,0,1,0,0,0,1; exactly 3 accepts; data intact.
- FIFO_DEPTH=4, no reads, 6 words offered -> 4 accepted, fifo_full=1, tready=0; one pop -> tready=1 the next cycle, 5th word accepted, count back to 4.
- Concurrent accept and pop every cycle across 10 words crossing pointer wrap (FIFO_DEPTH=4) -> fifo_count stays 1, output order 0..9, no loss.
- Accept word with tstrb=4'b0111, then assert reset mid-packet after 2 of 4 words -> strb_err=1 before reset; after reset all outputs at reset values and rd_empty=1.
- rd_en held while empty for 5 cycles, then 3 packets of 1 word each -> no state change while empty; pkt_count=3, pkt_avail clears only after the third pop.
